// File: rtl/uart_rx_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_param
// Description : UART receiver (5-8 data bits, optional parity, 1/2 stop bits,
//               break detection) with 3-sample majority voting on a 16x baud
//               tick, feeding a first-word-fall-through FIFO of 2**FIFO_AW
//               entries. Each entry carries data plus per-byte error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_param #(
  parameter int FIFO_AW     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               aresetn,
  input  logic               baud_tick,
  input  logic               rx,
  input  logic [1:0]         cfg_data_bits,
  input  logic               cfg_parity_en,
  input  logic               cfg_odd,
  input  logic               cfg_two_stop,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               rd_parity_err,
  output logic               rd_framing_err,
  output logic               rd_break,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  input  logic [FIFO_AW:0]   threshold,
  output logic               thresh_hit,
  output logic               overflow,
  input  logic               clear_overflow
);

  localparam int                 c_DEPTH_N = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   c_DEPTH   = (FIFO_AW+1)'(c_DEPTH_N);
  localparam logic [FIFO_AW:0]   c_LVL_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] c_PTR_ONE = FIFO_AW'(1);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_START    = 3'd1;
  localparam logic [2:0] c_DATA     = 3'd2;
  localparam logic [2:0] c_PARITY   = 3'd3;
  localparam logic [2:0] c_STOP1    = 3'd4;
  localparam logic [2:0] c_STOP2    = 3'd5;
  localparam logic [2:0] c_BRK_WAIT = 3'd6;

  // ---------------------------------------------------------------- receiver
  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_state;
  logic [3:0]             r_cnt;
  logic                   r_s7, r_s8;
  logic [2:0]             r_bit_idx;
  logic [7:0]             r_shift;
  logic [1:0]             r_nbits;
  logic                   r_par_en, r_odd, r_two_stop;
  logic                   r_par_bit, r_perr, r_ferr;
  logic                   r_push;
  logic [10:0]            r_entry;   // {break, framing, parity, data[7:0]}

  logic w_rxs, w_bit, w_resolve, w_last_bit;

  assign w_rxs      = r_sync[SYNC_STAGES-1];
  // Third vote is the live sample taken at count 9.
  assign w_bit      = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);
  assign w_resolve  = baud_tick && (r_cnt == 4'd9);
  // Last data bit index is 4..7, which is exactly {1, cfg_data_bits}.
  assign w_last_bit = (r_bit_idx == {1'b1, r_nbits});

  // rx synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) r_sync <= '1;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
  end

  // Bit timing, majority sampling and frame state machine
  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= c_IDLE;
      r_cnt      <= 4'd0;
      r_s7       <= 1'b1;
      r_s8       <= 1'b1;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_nbits    <= 2'd0;
      r_par_en   <= 1'b0;
      r_odd      <= 1'b0;
      r_two_stop <= 1'b0;
      r_par_bit  <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_push     <= 1'b0;
      r_entry    <= 11'd0;
    end else begin
      r_push <= 1'b0;
      if (baud_tick && (r_state != c_IDLE)) begin
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'd7) r_s7 <= w_rxs;
        if (r_cnt == 4'd8) r_s8 <= w_rxs;
      end
      case (r_state)
        c_IDLE: begin
          if (baud_tick && !w_rxs) begin
            r_cnt      <= 4'd0;
            r_state    <= c_START;
            r_nbits    <= cfg_data_bits;
            r_par_en   <= cfg_parity_en;
            r_odd      <= cfg_odd;
            r_two_stop <= cfg_two_stop;
            r_shift    <= 8'h00;
            r_bit_idx  <= 3'd0;
            r_par_bit  <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
          end
        end
        c_START: begin
          if (w_resolve) r_state <= w_bit ? c_IDLE : c_DATA;
        end
        c_DATA: begin
          if (w_resolve) begin
            r_shift[r_bit_idx] <= w_bit;
            r_bit_idx          <= r_bit_idx + 3'd1;
            if (w_last_bit) r_state <= r_par_en ? c_PARITY : c_STOP1;
          end
        end
        c_PARITY: begin
          if (w_resolve) begin
            r_par_bit <= w_bit;
            r_perr    <= ((^r_shift) ^ w_bit) != r_odd;
            r_state   <= c_STOP1;
          end
        end
        c_STOP1: begin
          if (w_resolve) begin
            if (!w_bit && (r_shift == 8'h00) && !r_par_bit) begin
              // Line held low through the whole frame: report a break.
              r_push  <= 1'b1;
              r_entry <= {1'b1, 1'b1, 1'b0, 8'h00};
              r_state <= c_BRK_WAIT;
            end else if (r_two_stop) begin
              r_ferr  <= !w_bit;
              r_state <= c_STOP2;
            end else begin
              r_push  <= 1'b1;
              r_entry <= {1'b0, !w_bit, r_perr, r_shift};
              r_state <= c_IDLE;
            end
          end
        end
        c_STOP2: begin
          if (w_resolve) begin
            r_push  <= 1'b1;
            r_entry <= {1'b0, r_ferr | !w_bit, r_perr, r_shift};
            r_state <= c_IDLE;
          end
        end
        c_BRK_WAIT: begin
          if (w_rxs) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------- FIFO
  logic [10:0]        r_mem [0:c_DEPTH_N-1];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_level;
  logic               r_empty, r_full, r_ovf, r_thresh;
  logic               w_pop, w_wr, w_ovf_set;
  logic [FIFO_AW:0]   w_level_next;
  logic [10:0]        w_head;

  // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
  assign w_pop     = rd_en && !r_empty;
  assign w_wr      = r_push && (!r_full || w_pop);
  assign w_ovf_set = r_push && r_full && !w_pop;

  // Occupancy after this cycle's accepted push/pop
  always_comb begin
    w_level_next = r_level;
    if (w_wr && !w_pop)      w_level_next = r_level + c_LVL_ONE;
    else if (!w_wr && w_pop) w_level_next = r_level - c_LVL_ONE;
  end

  // Entry storage; contents are don't-care until pointed at by valid level
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wptr] <= r_entry;
  end

  // Pointers, registered status flags and sticky overflow
  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_thresh <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop) r_rptr <= r_rptr + c_PTR_ONE;
      r_level  <= w_level_next;
      r_empty  <= (w_level_next == '0);
      r_full   <= (w_level_next == c_DEPTH);
      r_thresh <= (w_level_next >= threshold);
      if (w_ovf_set)           r_ovf <= 1'b1;
      else if (clear_overflow) r_ovf <= 1'b0;
    end
  end

  assign w_head         = r_mem[r_rptr];
  assign rd_data        = r_empty ? 8'h00 : w_head[7:0];
  assign rd_parity_err  = r_empty ? 1'b0  : w_head[8];
  assign rd_framing_err = r_empty ? 1'b0  : w_head[9];
  assign rd_break       = r_empty ? 1'b0  : w_head[10];
  assign empty          = r_empty;
  assign full           = r_full;
  assign level          = r_level;
  assign thresh_hit     = r_thresh;
  assign overflow       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo_param
// Description : Directed self-checking bench for uart_rx_fifo_param with a
//               4-entry FIFO and a baud tick every 4 CLK cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo_param;

  localparam int FIFO_AW = 2;

  logic               CLK = 1'b0;
  logic               aresetn = 1'b0;
  logic               baud_tick = 1'b0;
  logic               rx = 1'b1;
  logic [1:0]         cfg_data_bits = 2'b11;
  logic               cfg_parity_en = 1'b0;
  logic               cfg_odd = 1'b0;
  logic               cfg_two_stop = 1'b0;
  logic               rd_en = 1'b0;
  logic [7:0]         rd_data;
  logic               rd_parity_err, rd_framing_err, rd_break;
  logic               empty, full;
  logic [FIFO_AW:0]   level;
  logic [FIFO_AW:0]   threshold = '0;
  logic               thresh_hit, overflow;
  logic               clear_overflow = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int tdiv    = 0;

  uart_rx_fifo_param #(.FIFO_AW(FIFO_AW), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .aresetn(aresetn), .baud_tick(baud_tick), .rx(rx),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_odd(cfg_odd), .cfg_two_stop(cfg_two_stop), .rd_en(rd_en),
    .rd_data(rd_data), .rd_parity_err(rd_parity_err),
    .rd_framing_err(rd_framing_err), .rd_break(rd_break),
    .empty(empty), .full(full), .level(level), .threshold(threshold),
    .thresh_hit(thresh_hit), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 CLK = ~CLK;

  // 16x baud tick: one CLK high out of every four, changed on the falling edge
  always @(negedge CLK) begin
    tdiv      = (tdiv == 3) ? 0 : tdiv + 1;
    baud_tick = (tdiv == 3);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [7:0] d,
                            input logic p, input logic f, input logic b);
    check({tag, "_data"},  32'(rd_data),        32'(d));
    check({tag, "_par"},   32'(rd_parity_err),  32'(p));
    check({tag, "_frm"},   32'(rd_framing_err), 32'(f));
    check({tag, "_brk"},   32'(rd_break),       32'(b));
  endtask

  task automatic check_stat(input string tag, input logic e, input logic fu, input int lvl);
    check({tag, "_empty"}, 32'(empty), 32'(e));
    check({tag, "_full"},  32'(full),  32'(fu));
    check({tag, "_level"}, 32'(level), lvl);
  endtask

  // Waits for n baud ticks; returns 1 time unit after the last ticking edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      while (baud_tick !== 1'b1) @(posedge CLK);
    end
    #1;
  endtask

  // One 16-tick bit. The receiver resolves each bit 11 ticks after it starts
  // (1 tick to detect the start edge + counts 0..9); the push pulse follows on
  // the next CLK. mode: 0 plain, 1 one-tick spike on the count-8 sample,
  // 2 rd_en in push cycle, 3 clear_overflow in push cycle, 4 watch push timing.
  task automatic send_bit(input logic v, input int mode);
    rx = v;
    if (mode == 1) begin
      wait_ticks(9);
      rx = ~v;
      wait_ticks(1);
      rx = v;
      wait_ticks(6);
    end else if (mode >= 2) begin
      wait_ticks(11);
      if (mode == 2) rd_en = 1'b1;
      if (mode == 3) clear_overflow = 1'b1;
      if (mode == 4) check("push_cycle_empty", 32'(empty), 1);
      @(posedge CLK);
      #1;
      rd_en = 1'b0;
      clear_overflow = 1'b0;
      if (mode == 4) begin
        check("after_push_empty", 32'(empty), 0);
        check("after_push_level", 32'(level), 1);
      end
      wait_ticks(5);
    end else begin
      wait_ticks(16);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic pbit,
                            input logic s2, input int sp_idx, input int last_mode);
    wait_ticks(1);
    send_bit(1'b0, 0);
    for (int i = 0; i < nb; i++) send_bit(d[i], (i == sp_idx) ? 1 : 0);
    if (cfg_parity_en) send_bit(pbit, 0);
    if (cfg_two_stop) begin
      send_bit(1'b1, 0);
      send_bit(s2, last_mode);
    end else begin
      send_bit(1'b1, last_mode);
    end
    rx = 1'b1;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(posedge CLK);
    #1;
    rd_en = 1'b0;
  endtask

  initial begin
    // ---- reset state
    repeat (3) @(posedge CLK);
    #1;
    check_stat("rst", 1'b1, 1'b0, 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_thr", 32'(thresh_hit), 0);
    check_head("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    aresetn = 1'b1;
    @(posedge CLK);
    #1;
    check("thr_zero", 32'(thresh_hit), 1);
    threshold = 3;
    @(posedge CLK);
    #1;
    check("thr_three", 32'(thresh_hit), 0);

    // ---- 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b1, -1, 4);
    check_stat("a5", 1'b0, 1'b0, 1);
    check_head("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    pop();
    check_stat("a5_pop", 1'b1, 1'b0, 0);
    check("a5_pop_data", 32'(rd_data), 0);

    // ---- 7O2 0x3C: wrong parity, then bad second stop bit
    cfg_data_bits = 2'b10; cfg_parity_en = 1'b1; cfg_odd = 1'b1; cfg_two_stop = 1'b1;
    send_frame(8'h3C, 7, 1'b0, 1'b1, -1, 0);
    check_head("7o2_par", 8'h3C, 1'b1, 1'b0, 1'b0);
    pop();
    send_frame(8'h3C, 7, 1'b1, 1'b0, -1, 0);
    check_head("7o2_stp", 8'h3C, 1'b0, 1'b1, 1'b0);
    pop();
    wait_ticks(48);
    check_stat("7o2_done", 1'b1, 1'b0, 0);

    // ---- glitches
    cfg_data_bits = 2'b11; cfg_parity_en = 1'b0; cfg_odd = 1'b0; cfg_two_stop = 1'b0;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(48);
    check_stat("glitch", 1'b1, 1'b0, 0);
    send_frame(8'h0F, 8, 1'b0, 1'b1, 2, 0);
    send_frame(8'hF0, 8, 1'b0, 1'b1, 1, 0);
    check("spike_level", 32'(level), 2);
    check_head("spike1", 8'h0F, 1'b0, 1'b0, 1'b0);
    pop();
    check_head("spike2", 8'hF0, 1'b0, 1'b0, 1'b0);
    pop();

    // ---- break for two frame times, then a good frame
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(320);
    rx = 1'b1;
    wait_ticks(32);
    check("brk_level", 32'(level), 1);
    check_head("brk", 8'h00, 1'b0, 1'b1, 1'b1);
    send_frame(8'h55, 8, 1'b0, 1'b1, -1, 0);
    check("brk55_level", 32'(level), 2);
    pop();
    check_head("after_brk", 8'h55, 1'b0, 1'b0, 1'b0);
    pop();
    check_stat("brk_done", 1'b1, 1'b0, 0);

    // ---- threshold = 3
    send_frame(8'h01, 8, 1'b0, 1'b1, -1, 0);
    send_frame(8'h02, 8, 1'b0, 1'b1, -1, 0);
    check("thr_at2", 32'(thresh_hit), 0);
    send_frame(8'h03, 8, 1'b0, 1'b1, -1, 0);
    check("thr_at3", 32'(thresh_hit), 1);
    check("thr_lvl3", 32'(level), 3);
    pop();
    check("thr_pop", 32'(thresh_hit), 0);
    check("thr_pop_lvl", 32'(level), 2);
    check_head("thr_head", 8'h02, 1'b0, 1'b0, 1'b0);

    // ---- reset in the middle of the data bits
    wait_ticks(1);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    aresetn = 1'b0;
    rx = 1'b1;
    #1;
    check_stat("mid_rst", 1'b1, 1'b0, 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    check("mid_rst_thr", 32'(thresh_hit), 0);
    check_head("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    aresetn = 1'b1;
    wait_ticks(32);
    send_frame(8'hC3, 8, 1'b0, 1'b1, -1, 0);
    check("post_rst_level", 32'(level), 1);
    check_head("post_rst", 8'hC3, 1'b0, 1'b0, 1'b0);
    pop();

    // ---- overflow with a 4-entry FIFO
    send_frame(8'h11, 8, 1'b0, 1'b1, -1, 0);
    send_frame(8'h22, 8, 1'b0, 1'b1, -1, 0);
    send_frame(8'h33, 8, 1'b0, 1'b1, -1, 0);
    send_frame(8'h44, 8, 1'b0, 1'b1, -1, 0);
    send_frame(8'h55, 8, 1'b0, 1'b1, -1, 0);
    check_stat("ovf", 1'b0, 1'b1, 4);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_head", 32'(rd_data), 'h11);
    clear_overflow = 1'b1;
    @(posedge CLK);
    #1;
    clear_overflow = 1'b0;
    check("ovf_clear", 32'(overflow), 0);
    send_frame(8'h66, 8, 1'b0, 1'b1, -1, 2);
    check_stat("pushpop", 1'b0, 1'b1, 4);
    check("pushpop_ovf", 32'(overflow), 0);
    check("pushpop_head", 32'(rd_data), 'h22);
    send_frame(8'h77, 8, 1'b0, 1'b1, -1, 3);
    check("setwins_ovf", 32'(overflow), 1);
    check("setwins_level", 32'(level), 4);
    check("drain0", 32'(rd_data), 'h22);
    pop();
    check("drain1", 32'(rd_data), 'h33);
    pop();
    check("drain2", 32'(rd_data), 'h44);
    pop();
    check("drain3", 32'(rd_data), 'h66);
    pop();
    check_stat("drained", 1'b1, 1'b0, 0);
    pop();
    check("pop_empty_level", 32'(level), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
